// File: rtl/aes_key_loader.sv
// Captures a 128-bit key on a single-cycle strobe and streams it MSW-first as four 32-bit words.
// Optional KEY_CHANGE_ONLY_EN: drop strobes that repeat the most recently accepted key.
module aes_key_loader #(
  parameter int KEY_W  = 128,
  parameter int WORD_W = 32
) (
  input  logic              sclk,
  input  logic              rst_n,
  input  logic [KEY_W-1:0]  key_data,
  input  logic              en,
  output logic [WORD_W-1:0] word_out,
  output logic              word_valid,
  input  logic              word_ready,
  output logic [1:0]        word_idx,
  output logic              word_last,
  output logic              busy,
  output logic              done,
  output logic              overrun
);

  typedef enum logic {IDLE, SEND} state_e;

  state_e             state_q, state_d;
  logic [KEY_W-1:0]   shadow_q, shadow_d;
  logic [KEY_W-1:0]   pend_key_q, pend_key_d;
  logic               pend_vld_q, pend_vld_d;
  logic [1:0]         idx_q, idx_d;
  logic [WORD_W-1:0]  word_out_q, word_out_d;
  logic               done_q, done_d;
  logic               overrun_q, overrun_d;
  logic               en_acc;
  logic               hs;
  logic               final_hs;

`ifdef KEY_CHANGE_ONLY_EN
  logic [KEY_W-1:0]   last_key_q, last_key_d;
  logic               last_vld_q, last_vld_d;

  assign en_acc = en && !(last_vld_q && (key_data == last_key_q));

  always_comb begin
    last_key_d = last_key_q;
    last_vld_d = last_vld_q;
    if (en_acc) begin
      last_key_d = key_data;
      last_vld_d = 1'b1;
    end
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      last_key_q <= '0;
      last_vld_q <= 1'b0;
    end else begin
      last_key_q <= last_key_d;
      last_vld_q <= last_vld_d;
    end
  end
`else
  assign en_acc = en;
`endif

  assign hs       = (state_q == SEND) && word_ready;
  assign final_hs = hs && (idx_q == 2'd3);

  always_comb begin
    state_d    = state_q;
    shadow_d   = shadow_q;
    pend_key_d = pend_key_q;
    pend_vld_d = pend_vld_q;
    idx_d      = idx_q;
    done_d     = 1'b0;
    overrun_d  = overrun_q;
    word_out_d = word_out_q;

    case (state_q)
      IDLE: begin
        if (en_acc) begin
          shadow_d = key_data;
          idx_d    = 2'd0;
          state_d  = SEND;
        end
      end
      SEND: begin
        if (hs) begin
          if (!final_hs) begin
            idx_d = idx_q + 2'd1;
          end else begin
            done_d = 1'b1;
            idx_d  = 2'd0;
            if (pend_vld_q) begin
              shadow_d   = pend_key_q;
              pend_vld_d = 1'b0;
            end else begin
              state_d = IDLE;
            end
          end
        end
        // A strobe landing on the final handshake with no pending key bypasses the buffer.
        if (en_acc) begin
          if (final_hs && !pend_vld_q) begin
            shadow_d = key_data;
            state_d  = SEND;
          end else begin
            pend_key_d = key_data;
            pend_vld_d = 1'b1;
            if (pend_vld_q && !final_hs) overrun_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    case (idx_d)
      2'd0:    word_out_d = shadow_d[KEY_W-1          -: WORD_W];
      2'd1:    word_out_d = shadow_d[KEY_W-1-WORD_W   -: WORD_W];
      2'd2:    word_out_d = shadow_d[KEY_W-1-2*WORD_W -: WORD_W];
      default: word_out_d = shadow_d[WORD_W-1:0];
    endcase
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shadow_q   <= '0;
      pend_key_q <= '0;
      pend_vld_q <= 1'b0;
      idx_q      <= 2'd0;
      word_out_q <= '0;
      done_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      shadow_q   <= shadow_d;
      pend_key_q <= pend_key_d;
      pend_vld_q <= pend_vld_d;
      idx_q      <= idx_d;
      word_out_q <= word_out_d;
      done_q     <= done_d;
      overrun_q  <= overrun_d;
    end
  end

  assign word_out   = word_out_q;
  assign word_valid = (state_q == SEND);
  assign busy       = (state_q == SEND);
  assign word_idx   = idx_q;
  assign word_last  = (state_q == SEND) && (idx_q == 2'd3);
  assign done       = done_q;
  assign overrun    = overrun_q;

endmodule
